// File: rtl/microcode_loader.sv
`default_nettype none
// ============================================================================
// Module      : microcode_loader
// Description : Assembles 64-bit microcode words from 32-bit host halves and
//               commits them through the shared decode-table port, yielding
//               to decode lookups. Optional readback verify is enabled by
//               defining MICROCODE_LOADER_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module microcode_loader #(
    parameter int STARVE  = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [8:0]         host_addr,
    input  logic [31:0]        host_wdata,
    input  logic               dec_active,
    output logic               dec_stall,
    output logic [3:0]         mc_we,
    output logic               mc_re,
    output logic [5:0]         mc_index,
    output logic [63:0]        mc_wdata,
    input  logic [63:0]        mc_rdata,
    output logic               busy,
    output logic               err,
    output logic [COUNT_W-1:0] commit_count
);

    localparam int c_WAIT_W = $clog2(STARVE + 1);
    localparam logic [c_WAIT_W-1:0] c_STARVE_CNT = c_WAIT_W'(STARVE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_RDBK = 2'd2,
        S_CMP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic               r_lo_vld;
    logic [1:0]         r_lo_tbl;
    logic [5:0]         r_lo_idx;
    logic [31:0]        r_lo_data;
    logic [1:0]         r_tbl;
    logic [5:0]         r_index;
    logic [63:0]        r_word;
    logic               r_err;
    logic [COUNT_W-1:0] r_count;
    logic [c_WAIT_W-1:0] r_wait;

    logic       w_accept;
    logic [1:0] w_tbl;
    logic [5:0] w_idx;
    logic       w_half;
    logic       w_pair_ok;
    logic       w_range_bad;
    logic       w_hi_good;
    logic       w_hi_bad;
    logic       w_port_free;
    logic       w_wr_fire;
    logic       w_count_inc;
    logic       w_cmp_fail;

    assign w_tbl       = host_addr[8:7];
    assign w_idx       = host_addr[6:1];
    assign w_half      = host_addr[0];
    assign w_accept    = host_valid & host_ready;
    assign w_pair_ok   = r_lo_vld & (w_tbl == r_lo_tbl) & (w_idx == r_lo_idx);
    // regimm and cp0 tables hold only 32 entries
    assign w_range_bad = w_tbl[1] & w_idx[5];
    assign w_hi_good   = w_accept & w_half & w_pair_ok & ~w_range_bad;
    assign w_hi_bad    = w_accept & w_half & ~(w_pair_ok & ~w_range_bad);
    assign w_port_free = ~dec_active;
    assign w_wr_fire   = (r_state == S_PEND) & w_port_free & ~rst;

`ifdef MICROCODE_LOADER_VERIFY_EN
    assign mc_re = (r_state == S_RDBK) & w_port_free & ~rst;
`else
    logic w_unused;
    assign w_unused = ^mc_rdata;
    assign mc_re    = 1'b0;
`endif

    always_comb begin
        w_next      = r_state;
        w_count_inc = 1'b0;
        w_cmp_fail  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hi_good) begin
                    w_next = S_PEND;
                end
            end
            S_PEND: begin
                if (w_port_free) begin
`ifdef MICROCODE_LOADER_VERIFY_EN
                    w_next = S_RDBK;
`else
                    w_next      = S_IDLE;
                    w_count_inc = 1'b1;
`endif
                end
            end
`ifdef MICROCODE_LOADER_VERIFY_EN
            S_RDBK: begin
                if (w_port_free) begin
                    w_next = S_CMP;
                end
            end
            S_CMP: begin
                w_next = S_IDLE;
                if (mc_rdata == r_word) begin
                    w_count_inc = 1'b1;
                end else begin
                    w_cmp_fail = 1'b1;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lo_vld  <= 1'b0;
            r_lo_tbl  <= 2'd0;
            r_lo_idx  <= 6'd0;
            r_lo_data <= 32'd0;
            r_tbl     <= 2'd0;
            r_index   <= 6'd0;
            r_word    <= 64'd0;
            r_err     <= 1'b0;
            r_count   <= '0;
            r_wait    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_half) begin
                r_lo_vld  <= 1'b1;
                r_lo_tbl  <= w_tbl;
                r_lo_idx  <= w_idx;
                r_lo_data <= host_wdata;
            end else if (w_accept && w_half) begin
                r_lo_vld  <= 1'b0;
            end
            if (w_hi_good) begin
                r_tbl   <= w_tbl;
                r_index <= w_idx;
                r_word  <= {host_wdata, r_lo_data};
            end
            if (w_hi_bad || w_cmp_fail) begin
                r_err <= 1'b1;
            end
            if (w_count_inc) begin
                r_count <= r_count + 1'b1;
            end
            // Saturating count of blocked cycles; any port access clears it
            if (((r_state == S_PEND) || (r_state == S_RDBK)) && dec_active) begin
                if (r_wait != c_STARVE_CNT) begin
                    r_wait <= r_wait + 1'b1;
                end
            end else begin
                r_wait <= '0;
            end
        end
    end

    assign host_ready   = (r_state == S_IDLE) & ~rst;
    assign busy         = (r_state != S_IDLE);
    assign dec_stall    = (r_wait == c_STARVE_CNT);
    assign mc_we        = w_wr_fire ? (4'b0001 << r_tbl) : 4'b0000;
    assign mc_index     = r_index;
    assign mc_wdata     = r_word;
    assign err          = r_err;
    assign commit_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_microcode_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_microcode_loader
// Description : Self-checking bench: vector table, hand-written corner
//               sequences and randomized traffic against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microcode_loader;

    localparam int c_CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            host_valid = 1'b0;
    logic            host_ready;
    logic [8:0]      host_addr = 9'd0;
    logic [31:0]     host_wdata = 32'd0;
    logic            dec_active = 1'b0;
    logic            dec_stall;
    logic [3:0]      mc_we;
    logic            mc_re;
    logic [5:0]      mc_index;
    logic [63:0]     mc_wdata;
    logic [63:0]     mc_rdata = 64'd0;
    logic            busy;
    logic            err;
    logic [c_CW-1:0] commit_count;

    microcode_loader #(.STARVE(8), .COUNT_W(c_CW)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .dec_active(dec_active), .dec_stall(dec_stall),
        .mc_we(mc_we), .mc_re(mc_re), .mc_index(mc_index),
        .mc_wdata(mc_wdata), .mc_rdata(mc_rdata),
        .busy(busy), .err(err), .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference model
    typedef struct {
        logic [1:0]  t;
        logic [5:0]  i;
        logic [63:0] w;
        bit          bad;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    bit          m_lo_vld;
    logic [1:0]  m_lo_t;
    logic [5:0]  m_lo_i;
    logic [31:0] m_lo_d;
    bit          m_err;
    int          m_commits;
    int          wr_seen = 0;
    bit          corrupt_next = 1'b0;
    bit          rand_dec = 1'b0;

    function automatic void model_reset();
        m_lo_vld  = 1'b0;
        m_err     = 1'b0;
        m_commits = 0;
        exp_q.delete();
    endfunction

    function automatic void model_beat(input logic [1:0] t, input logic [5:0] i,
                                       input bit h, input logic [31:0] d);
        wr_t e;
        if (!h) begin
            m_lo_vld = 1'b1;
            m_lo_t   = t;
            m_lo_i   = i;
            m_lo_d   = d;
        end else begin
            if (m_lo_vld && t == m_lo_t && i == m_lo_i && !(t >= 2 && i >= 32)) begin
                e.t = t;
                e.i = i;
                e.w = {d, m_lo_d};
                e.bad = corrupt_next;
                exp_q.push_back(e);
`ifdef MICROCODE_LOADER_VERIFY_EN
                if (corrupt_next) m_err = 1'b1;
                else m_commits++;
`else
                m_commits++;
`endif
            end else begin
                m_err = 1'b1;
            end
            m_lo_vld = 1'b0;
        end
    endfunction

    // Table-port monitor and table memory model
    logic [63:0] mem [4][64];
    logic [1:0]  last_t;
    logic [5:0]  last_i;
    bit          last_bad;

    always @(negedge clk) begin
        if (!rst) begin
            if (mc_we != 4'b0000) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {60'd0, mc_we}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("we_onehot", {60'd0, mc_we}, 64'd1 << mon_e.t);
                    check("we_index", {58'd0, mc_index}, {58'd0, mon_e.i});
                    check("we_data", mc_wdata, mon_e.w);
                    check("we_re_exclusive", {63'd0, mc_re}, 64'd0);
                    mem[mon_e.t][mon_e.i] = mc_wdata;
                    last_t   = mon_e.t;
                    last_i   = mon_e.i;
                    last_bad = mon_e.bad;
                end
            end
            if (mc_re) begin
                check("re_index", {58'd0, mc_index}, {58'd0, last_i});
                mc_rdata = mem[last_t][last_i] ^ (last_bad ? 64'h1 : 64'h0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_dec) dec_active = ($urandom_range(0, 2) == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        host_valid = 1'b0;
        corrupt_next = 1'b0;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [1:0] t, input logic [5:0] i,
                             input bit h, input logic [31:0] d);
        int n = 0;
        host_valid = 1'b1;
        host_addr  = {t, i, h};
        host_wdata = d;
        @(negedge clk);
        while (!host_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!host_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: host_ready still 0 after %0d cycles", n);
        end
        check("idle_count", {60'd0, commit_count}, 64'(m_commits & 15));
        check("idle_err", {63'd0, err}, {63'd0, m_err});
        tick();
        host_valid = 1'b0;
        model_beat(t, i, h, d);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
        end
        tick();
    endtask

    typedef struct {
        bit          has_lo;
        logic [1:0]  lt;
        logic [5:0]  li;
        logic [1:0]  ht;
        logic [5:0]  hi;
        logic [63:0] w;
        int          x_write;
        bit          x_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int wr0;
        vecs[0] = '{1'b1, 2'd0, 6'h2A, 2'd0, 6'h2A, 64'h1234_5678_9ABC_DEF0, 1, 1'b0};
        vecs[1] = '{1'b0, 2'd1, 6'h05, 2'd1, 6'h05, 64'hAAAA_0000_5555_1111, 0, 1'b1};
        vecs[2] = '{1'b1, 2'd1, 6'h05, 2'd1, 6'h06, 64'h0BAD_0BAD_0BAD_0BAD, 0, 1'b1};
        vecs[3] = '{1'b1, 2'd3, 6'h20, 2'd3, 6'h20, 64'hCAFE_F00D_DEAD_BEEF, 0, 1'b1};
        vecs[4] = '{1'b1, 2'd2, 6'h1F, 2'd2, 6'h1F, 64'h0102_0304_0506_0708, 1, 1'b0};
        vecs[5] = '{1'b1, 2'd2, 6'h3F, 2'd2, 6'h3F, 64'hFFFF_0000_FFFF_0000, 0, 1'b1};
        vecs[6] = '{1'b1, 2'd0, 6'h3F, 2'd0, 6'h3F, 64'h8000_0000_0000_0001, 1, 1'b0};
        vecs[7] = '{1'b1, 2'd0, 6'h03, 2'd1, 6'h03, 64'h1111_2222_3333_4444, 0, 1'b1};

        // Reset values
        model_reset();
        tick();
        @(negedge clk);
        check("rst_host_ready", {63'd0, host_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_count", {60'd0, commit_count}, 64'd0);
        check("rst_we", {60'd0, mc_we}, 64'd0);
        check("rst_re", {63'd0, mc_re}, 64'd0);
        check("rst_index", {58'd0, mc_index}, 64'd0);
        check("rst_wdata", mc_wdata, 64'd0);
        check("rst_stall", {63'd0, dec_stall}, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {63'd0, host_ready}, 64'd1);
        tick();

        // Vector table
        for (int k = 0; k < 8; k++) begin
            do_reset();
            dec_active = 1'b0;
            wr0 = wr_seen;
            if (vecs[k].has_lo) send_beat(vecs[k].lt, vecs[k].li, 1'b0, vecs[k].w[31:0]);
            send_beat(vecs[k].ht, vecs[k].hi, 1'b1, vecs[k].w[63:32]);
            wait_idle();
            check($sformatf("vec%0d_writes", k), 64'(wr_seen - wr0), 64'(vecs[k].x_write));
            check($sformatf("vec%0d_err", k), {63'd0, err}, {63'd0, vecs[k].x_err});
            check($sformatf("vec%0d_count", k), {60'd0, commit_count}, 64'(vecs[k].x_write));
        end

        // Write latency
        do_reset();
        dec_active = 1'b0;
        send_beat(2'd0, 6'h2A, 1'b0, 32'h9ABC_DEF0);
        send_beat(2'd0, 6'h2A, 1'b1, 32'h1234_5678);
        @(negedge clk);
        check("lat_we", {60'd0, mc_we}, 64'h1);
        check("lat_index", {58'd0, mc_index}, 64'h2A);
        check("lat_wdata", mc_wdata, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        check("lat_we_once", {60'd0, mc_we}, 64'h0);
`ifdef MICROCODE_LOADER_VERIFY_EN
        check("lat_re", {63'd0, mc_re}, 64'h1);
        @(negedge clk);
        check("lat_re_once", {63'd0, mc_re}, 64'h0);
        check("lat_cmp_busy", {63'd0, busy}, 64'h1);
        @(negedge clk);
`endif
        check("lat_count", {60'd0, commit_count}, 64'h1);
        check("lat_idle", {63'd0, busy}, 64'h0);
        tick();

        // Starvation
        do_reset();
        dec_active = 1'b0;
        send_beat(2'd1, 6'h03, 1'b0, 32'h0000_0003);
        dec_active = 1'b1;
        send_beat(2'd1, 6'h03, 1'b1, 32'h3000_0000);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("starve_nostall_%0d", k), {63'd0, dec_stall}, 64'd0);
            check($sformatf("starve_blocked_%0d", k), {60'd0, mc_we}, 64'd0);
        end
        @(negedge clk);
        check("starve_stall", {63'd0, dec_stall}, 64'd1);
        tick();
        dec_active = 1'b0;
        @(negedge clk);
        check("starve_we", {60'd0, mc_we}, 64'h2);
        check("starve_stall_hold", {63'd0, dec_stall}, 64'd1);
        @(negedge clk);
        check("starve_stall_clear", {63'd0, dec_stall}, 64'd0);
        tick();
        wait_idle();
        check("starve_count", {60'd0, commit_count}, 64'd1);

        // Reset while PEND is blocked
        do_reset();
        dec_active = 1'b1;
        send_beat(2'd0, 6'h01, 1'b1, 32'h1);
        send_beat(2'd0, 6'h04, 1'b0, 32'h4444);
        send_beat(2'd0, 6'h04, 1'b1, 32'h5555);
        tick();
        tick();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("rstp_ready_low", {63'd0, host_ready}, 64'd0);
        check("rstp_no_we", {60'd0, mc_we}, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstp_ready", {63'd0, host_ready}, 64'd1);
        check("rstp_busy", {63'd0, busy}, 64'd0);
        check("rstp_err", {63'd0, err}, 64'd0);
        check("rstp_count", {60'd0, commit_count}, 64'd0);
        tick();
        dec_active = 1'b0;
        wr0 = wr_seen;
        repeat (6) tick();
        check("rstp_no_write", 64'(wr_seen - wr0), 64'd0);

`ifdef MICROCODE_LOADER_VERIFY_EN
        // Readback verify
        do_reset();
        dec_active = 1'b0;
        corrupt_next = 1'b1;
        send_beat(2'd1, 6'h07, 1'b0, 32'h7777_0000);
        send_beat(2'd1, 6'h07, 1'b1, 32'h0000_7777);
        wait_idle();
        check("vfy_bad_err", {63'd0, err}, 64'd1);
        check("vfy_bad_count", {60'd0, commit_count}, 64'd0);
        corrupt_next = 1'b0;
        send_beat(2'd1, 6'h08, 1'b0, 32'h8888_1111);
        send_beat(2'd1, 6'h08, 1'b1, 32'h2222_8888);
        wait_idle();
        check("vfy_good_count", {60'd0, commit_count}, 64'd1);
`endif

        // Randomized traffic with random decode contention
        do_reset();
        rand_dec = 1'b1;
        for (int k = 0; k < 250; k++) begin
            logic [1:0] t;
            logic [5:0] i;
            t = 2'($urandom_range(0, 3));
            i = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 7) begin
                send_beat(t, i, 1'b0, $urandom);
                send_beat(t, i, 1'b1, $urandom);
            end else begin
                send_beat(t, i ^ 6'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end
        end
        rand_dec = 1'b0;
        tick();
        dec_active = 1'b0;
        wait_idle();
        check("rand_err", {63'd0, err}, {63'd0, m_err});
        check("rand_count", {60'd0, commit_count}, 64'(m_commits & 15));
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/microcode_loader.md
# microcode_loader

Runtime loader and port arbiter for the four decode microcode tables: control (64 entries), alufunc (64), regimm (32) and cp0 (32). A host writes 64-bit microcode words as two 32-bit halves over a valid/ready port. The loader assembles each word and commits it through the single shared table write/read port, yielding to the decode stage's lookups. It sits beside the decode stage and owns the table write side; the decode stage keeps its lookup-index path.

## Interface
- `STARVE`, default 8: consecutive cycles of pending-and-blocked before the loader asserts `dec_stall`.
- `COUNT_W`, default 16: width of `commit_count`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `host_valid`  in  1  host beat valid.
- `host_ready`  out  1  loader accepts the beat this cycle.
- `host_addr`  in  9  [8:7] table (0 control, 1 alufunc, 2 regimm, 3 cp0); [6:1] index; [0] half (0 low, 1 high).
- `host_wdata`  in  32  half-word data.
- `dec_active`  in  1  decode stage uses the table port this cycle.
- `dec_stall`  out  1  request for decode to freeze so the loader can take the port.
- `mc_we`  out  4  one-hot table write enable, one cycle.
- `mc_re`  out  1  readback strobe (only with verify).
- `mc_index`  out  6  table index for write/readback.
- `mc_wdata`  out  64  `{hi, lo}` word.
- `mc_rdata`  in  64  table read data, valid the cycle after `mc_re`.
- `busy`  out  1  FSM not in IDLE.
- `err`  out  1  sticky error flag; cleared only by `rst`.
- `commit_count`  out  COUNT_W  successful commits; wraps at 2^COUNT_W.

## Operation
- A beat is accepted when `host_valid && host_ready`. `host_ready` is 1 only in IDLE.
- **Low-half beat:** stores data, table and index into `lo_reg`; sets `lo_vld`. A second low half overwrites the first (no error).
- **High-half beat, accepted:** if `lo_vld` and table/index match `lo_reg`:
  - latch the word, clear `lo_vld`, go to PEND.
- **High-half beat, rejected:** if `lo_vld` is 0, or the table/index mismatch:
  - set `err`, clear `lo_vld`, stay in IDLE, do not write.
- **Range check:** a high half addressed to regimm/cp0 with index[5]=1 sets `err` and is dropped, even when it pairs correctly.
- **FSM states:** IDLE, PEND, RDBK, CMP.
  - **PEND:** if `!dec_active`, pulse `mc_we[table]` with `mc_index` and `mc_wdata`. Then go to RDBK (verify on) or IDLE (verify off), incrementing `commit_count` on the non-verify path. Otherwise wait.
  - **RDBK:** if `!dec_active`, pulse `mc_re` with the same index and go to CMP; otherwise wait.
  - **CMP:** compare `mc_rdata` with the word. On match, increment `commit_count`; on mismatch, set `err` with no increment. Go to IDLE.
- **Arbitration:** decode always wins a same-cycle conflict. A wait counter increments each cycle spent in PEND or RDBK with `dec_active`=1, and clears on leaving those states. When it reaches `STARVE`, `dec_stall`=1 until the pending port access completes.
- `mc_index`/`mc_wdata` hold their values from PEND entry to IDLE return. `mc_we`/`mc_re` are never asserted together or for more than one cycle per word.

## Timing
- **Reset values:** `host_ready`=0 during reset, 1 the first cycle after; all other outputs (`dec_stall`, `mc_we`, `mc_re`, `mc_index`, `mc_wdata`, `busy`, `err`, `commit_count`) are 0; `lo_vld`=0; wait counter=0.
- **Write latency:** high-half accept at cycle N, `dec_active`=0 → `mc_we` at N+1.
- **Verify latency:** `mc_re` at N+2; compare at N+3; `commit_count` updates at N+4 (counter value visible).
- **Next host beat:** accepted in the cycle after return to IDLE.
- **Starvation:** with `dec_active` held high, `dec_stall` rises in the cycle after the `STARVE`-th blocked cycle and falls the cycle after `mc_we` (or `mc_re`) fires.
- **Reset mid-operation:**
  - a pending word is discarded; no write is issued;
  - `lo_vld` and the FSM clear;
  - `err` and `commit_count` clear.
- **Wrap:** `commit_count` rolls from all-ones to 0 with no flag.

## Configuration
- `MICROCODE_LOADER_VERIFY_EN`:
  - **Defined:** RDBK/CMP states exist; readback mismatch sets `err`; `commit_count` counts verified commits only.
  - **Undefined:** `mc_re` is tied to 0; PEND returns directly to IDLE; `mc_rdata` is ignored; `commit_count` counts writes.

## Test plan
- **Basic write:** low+high halves for control index 0x2A, data 0x1234_5678_9ABC_DEF0, `dec_active`=0 → `mc_we`=4'b0001, `mc_index`=0x2A, `mc_wdata`=0x123456789ABCDEF0 one cycle after the high-half accept; `commit_count`=1.
- **Pairing errors:**
  - high half to alufunc index 5 with no prior low half → `err`=1, no `mc_we`;
  - low at index 5, high at index 6 → `err`=1, no write.
- **Range:** cp0 index 0x20 pair → `err`=1, no write, `commit_count` unchanged.
- **Starvation:** `dec_active` held 1 after the high half, `STARVE`=8 → `dec_stall`=1 after 8 blocked cycles. Drop `dec_active` → `mc_we` next cycle, `dec_stall` clears the cycle after.
- **Verify (`MICROCODE_LOADER_VERIFY_EN` defined):**
  - return `mc_rdata` ≠ word → `err`=1, count unchanged;
  - return a matching word → count+1.
- **Reset in PEND:** `rst`=1 one cycle while PEND is blocked → no `mc_we` ever; `busy`=0, `err`=0, `commit_count`=0; `host_ready`=1 the cycle after `rst` deasserts.
